// File: rtl/req_encoder4to2.sv
`default_nettype none
// ============================================================================
// Module   : req_encoder4to2
// Purpose  : Sequential priority encoder. Captures a multi-hot request bitmap
//            through a valid/ready handshake, then streams out the binary
//            index of each set bit, lowest index first, one index per output
//            handshake. Each bit is cleared as its index is consumed.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            en         - enable, gates acceptance of new vectors only
//            req        - request bitmap, bit i requests index i
//            req_valid  - req is valid
//            req_ready  - block can accept a vector (combinational)
//            y          - index of the current lowest pending bit
//            y_valid    - y is valid
//            y_ready    - consumer accepts y
//            pending    - set bits still held, including the one on y
//            multi      - last nonzero captured vector had >1 bit set
//            zero_err   - one-cycle pulse: an accepted vector was all zeros
// Revision : 1.0 - initial release
// ============================================================================
module req_encoder4to2 #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N-1:0]         req,
  input  logic                 req_valid,
  output logic                 req_ready,
  output logic [$clog2(N)-1:0] y,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic [$clog2(N):0]   pending,
  output logic                 multi,
  output logic                 zero_err
);

  localparam int W  = $clog2(N);
  localparam int CW = W + 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [N-1:0]   r_pend;
  logic [N-1:0]   w_pend_cleared;
  logic [W-1:0]   w_req_lsb;
  logic [W-1:0]   w_clr_lsb;
  logic [CW-1:0]  w_req_cnt;
  logic           w_accept;
  logic           w_consume;

  // Index of the lowest set bit; scanning downward lets the lowest hit win.
  function automatic logic [W-1:0] lowest_index(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = W'(i);
    end
    return idx;
  endfunction

  function automatic logic [CW-1:0] pop_count(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // rst_n is folded in so the upstream never sees ready while reset is held.
  assign req_ready = (r_state == IDLE) && en && rst_n;

  // The bit currently shown on y is the one retired by an output handshake.
  assign w_pend_cleared = r_pend & ~(N'(1) << y);
  assign w_req_lsb      = lowest_index(req);
  assign w_clr_lsb      = lowest_index(w_pend_cleared);
  assign w_req_cnt      = pop_count(req);

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_consume    = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept = req_valid && req_ready;
        if (w_accept && (req != '0)) w_state_next = DRAIN;
      end
      DRAIN: begin
        w_consume = y_valid && y_ready;
        if (w_consume && (w_pend_cleared == '0)) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend   <= '0;
      y        <= '0;
      y_valid  <= 1'b0;
      pending  <= '0;
      multi    <= 1'b0;
      zero_err <= 1'b0;
    end else begin
      zero_err <= 1'b0;
      if (w_accept) begin
        if (req != '0) begin
          r_pend  <= req;
          y       <= w_req_lsb;
          y_valid <= 1'b1;
          pending <= w_req_cnt;
          multi   <= (w_req_cnt > CW'(1));
        end else begin
          // Empty vector is consumed but produces no output stream.
          zero_err <= 1'b1;
        end
      end else if (w_consume) begin
        r_pend  <= w_pend_cleared;
        pending <= pending - CW'(1);
        if (w_pend_cleared != '0) begin
          y <= w_clr_lsb;
        end else begin
          // Last index consumed: y keeps its final value.
          y_valid <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_req_encoder4to2.sv
`default_nettype none
// ============================================================================
// Module   : tb_req_encoder4to2
// Purpose  : Self-checking bench for req_encoder4to2. The reference model
//            holds the outstanding indices as a queue built from the set bits
//            of each accepted vector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_req_encoder4to2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] req = '0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] y;
  logic       y_valid;
  logic       y_ready = 1'b0;
  logic [2:0] pending;
  logic       multi;
  logic       zero_err;

  req_encoder4to2 #(.N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .y         (y),
    .y_valid   (y_valid),
    .y_ready   (y_ready),
    .pending   (pending),
    .multi     (multi),
    .zero_err  (zero_err)
  );

  always #5 clk = ~clk;

  // Reference model state
  int q[$];
  int m_y     = 0;
  bit m_multi = 1'b0;
  bit m_zero  = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return (q.size() == 0) && (en === 1'b1) && (rst_n === 1'b1);
  endfunction

  task automatic model_reset();
    q.delete();
    m_y     = 0;
    m_multi = 1'b0;
    m_zero  = 1'b0;
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".y_valid"},  y_valid,  (q.size() > 0));
    chk({ctx, ".y"},        y,        m_y);
    chk({ctx, ".pending"},  pending,  q.size());
    chk({ctx, ".multi"},    multi,    m_multi);
    chk({ctx, ".zero_err"}, zero_err, m_zero);
  endtask

  // Called at a falling edge: drive inputs, check ready, advance one edge,
  // update the model, check registered outputs, return at the falling edge.
  task automatic cycle(input string ctx, input logic [3:0] r, input logic rv,
                       input logic e, input logic yr);
    bit rdy;
    req = r; req_valid = rv; en = e; y_ready = yr;
    #1;
    rdy = m_ready();
    chk({ctx, ".req_ready"}, req_ready, rdy);
    @(posedge clk);
    if (rst_n !== 1'b1) begin
      model_reset();
    end else begin
      m_zero = 1'b0;
      if (q.size() > 0) begin
        if (yr) m_y = q.pop_front();
      end else if (rdy && rv) begin
        if (r == 4'b0000) begin
          m_zero = 1'b1;
        end else begin
          for (int i = 0; i < 4; i++) if (r[i]) q.push_back(i);
          m_multi = (q.size() > 1);
        end
      end
      if (q.size() > 0) m_y = q[0];
    end
    #1;
    check_outputs(ctx);
    @(negedge clk);
  endtask

  task automatic async_reset_pulse(input string ctx);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk({ctx, ".req_ready"}, req_ready, 0);
    check_outputs(ctx);
    @(negedge clk);
    cycle({ctx, "_hold"}, 4'b0000, 1'b0, 1'b1, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    // Reset values
    en = 1'b1;
    cycle("rst0", 4'b0000, 1'b0, 1'b1, 1'b0);
    cycle("rst1", 4'b0101, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    cycle("rel", 4'b0000, 1'b0, 1'b1, 1'b0);

    // One-hot vectors decode back to their index
    for (int k = 0; k < 4; k++) begin
      cycle("onehot_acc", 4'(1 << k), 1'b1, 1'b1, 1'b1);
      cycle("onehot_done", 4'b0000, 1'b0, 1'b1, 1'b1);
    end

    // Multi-hot with stall; requests offered during drain are ignored
    cycle("mh_acc", 4'b1011, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cycle("mh_stall", 4'b0100, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cycle("mh_drain", 4'b0100, 1'b1, 1'b1, 1'b1);
    cycle("mh_idle", 4'b0000, 1'b0, 1'b1, 1'b1);

    // Zero vector and enable gating
    cycle("zero_acc", 4'b0000, 1'b1, 1'b1, 1'b0);
    cycle("zero_after", 4'b0000, 1'b0, 1'b1, 1'b0);
    cycle("en_off0", 4'b0100, 1'b1, 1'b0, 1'b0);
    cycle("en_off1", 4'b0100, 1'b1, 1'b0, 1'b1);
    cycle("en_drop_acc", 4'b1111, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) cycle("en_drop_drain", 4'b0000, 1'b0, 1'b0, 1'b1);

    // Reset mid-drain
    cycle("mid_acc", 4'b1110, 1'b1, 1'b1, 1'b0);
    cycle("mid_hs", 4'b0000, 1'b0, 1'b1, 1'b1);
    async_reset_pulse("mid_rst");
    for (int k = 0; k < 3; k++) cycle("mid_after", 4'b0000, 1'b0, 1'b1, 1'b1);

    // Back-to-back vectors with one bubble
    cycle("b2b_a", 4'b1000, 1'b1, 1'b1, 1'b1);
    cycle("b2b_busy", 4'b0011, 1'b1, 1'b1, 1'b1);
    cycle("b2b_bubble", 4'b0011, 1'b1, 1'b1, 1'b1);
    cycle("b2b_d0", 4'b0000, 1'b0, 1'b1, 1'b1);
    cycle("b2b_d1", 4'b0000, 1'b0, 1'b1, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [3:0] r;
      r = 4'($urandom);
      if ($urandom_range(0, 7) == 0) r = 4'b0000;
      if ($urandom_range(0, 63) == 0) begin
        async_reset_pulse("rnd_rst");
      end else begin
        cycle("rnd", r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0),
              ($urandom_range(0, 2) != 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/req_encoder4to2.md
# req_encoder4to2

Sequential priority encoder: the inverse of the team's 2-to-4 decoder. It captures a multi-hot request vector through a valid/ready handshake. It then emits the binary index of each set bit, lowest index first, one index per output handshake, clearing each bit as it is consumed. It sits in front of the decoder (or any index consumer) to turn a request bitmap into a stream of select codes.

## Interface
- `N`, default 4: request vector width; must be a power of two, 2..16.
- `W`, default `$clog2(N)` = 2: index width; derived, not overridden.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `en`  in  1: enable; gates acceptance of new vectors only.
- `req`  in  N: request bitmap; bit i requests index i.
- `req_valid`  in  1: `req` is valid this cycle.
- `req_ready`  out  1: block can accept a vector.
- `y`  out  W: encoded index of the current lowest pending bit.
- `y_valid`  out  1: `y` is valid.
- `y_ready`  in  1: consumer accepts `y`.
- `pending`  out  W+1: number of set bits still held, including the one shown on `y`.
- `multi`  out  1: the captured vector had more than one bit set.
- `zero_err`  out  1: single-cycle pulse; an accepted vector was all zeros.

## Operation
- State register `pend[N-1:0]`, two-state FSM: IDLE and DRAIN.
- `req_ready` = (state == IDLE) && `en` && `rst_n`. It is deasserted throughout DRAIN.
- **IDLE, accept with `req != 0`.** Accept occurs when `req_valid && req_ready`:
  - `pend` <= `req`.
  - `y` <= index of the lowest set bit of `req`.
  - `y_valid` <= 1.
  - `pending` <= popcount(`req`).
  - `multi` <= (popcount > 1).
  - Next state is DRAIN.
- **IDLE, accept with `req == 0`.** The vector is consumed and `zero_err` pulses high for exactly one cycle. The state stays IDLE, `pend` stays 0 and `y_valid` stays 0.
- **DRAIN, output handshake.** On `y_valid && y_ready`:
  - `pend` <= `pend` & ~(1 << `y`).
  - `pending` <= `pending` − 1.
  - If the new `pend` is nonzero, `y` <= its lowest set index and `y_valid` stays 1.
  - Otherwise `y_valid` <= 0, `y` holds its last value and the next state is IDLE.
- **DRAIN, no handshake.** `y`, `y_valid`, `pending` and `multi` hold stable; no output changes while stalled.
- **`en` low.** It blocks acceptance in IDLE. It does not stall or abort a drain in progress.
- **`multi`.** Updated only on a nonzero accept; it holds until the next nonzero accept.
- **Priority.** LSB first, so the decoder mapping is inverted exactly: 0001→0, 0010→1, 0100→2, 1000→3.
- **Reset.** Asserting `rst_n` low at any time, including mid-drain, discards `pend` immediately. All outputs then take their reset values:
  - `pend` = 0, state = IDLE.
  - `y` = 0, `y_valid` = 0, `pending` = 0.
  - `multi` = 0, `zero_err` = 0.
  - `req_ready` = 0 (while `rst_n` is low).

## Timing
- All outputs except `req_ready` are registered. `req_ready` is combinational from the state register, `en` and `rst_n`.
- Accept at edge k gives `y_valid` = 1 with the first index from edge k onward. Capture-to-output latency is 1 cycle.
- Throughput is one index per cycle while `y_ready` is held high.
- A vector with p set bits keeps the block in DRAIN for at least p cycles.
- The earliest next accept is the edge after the cycle in which the last handshake occurs. There is one bubble cycle, in which `req_ready` = 1.
- `req` and `req_valid` are ignored whenever `req_ready` = 0. Inputs offered during DRAIN are not queued.
- `zero_err` is high in the cycle after the accepting edge only.

## Test plan
- **Reset values.** Hold `rst_n` = 0 with `en` = 1 → `req_ready` = 0, `y_valid` = 0, `y` = 0, `pending` = 0. Release → `req_ready` = 1 in the next cycle.
- **Inverse of decoder.** Send one-hot vectors 0001, 0010, 0100, 1000 with `y_ready` = 1. Each yields a single `y` of 0, 1, 2, 3 respectively with `pending` = 1 and `multi` = 0, then returns to IDLE.
- **Multi-hot drain with stall.** Send `req` = 1011 and hold `y_ready` = 0 for 3 cycles:
  - Outputs hold at `y` = 0, `pending` = 3, `multi` = 1.
  - Then set `y_ready` = 1 → `y` sequence 0, 1, 3 on consecutive cycles, then `y_valid` = 0.
  - `req_valid` offered during the drain is not accepted.
- **Zero vector and enable gating.**
  - `req` = 0000 accepted → `zero_err` is a 1-cycle pulse and `y_valid` stays 0.
  - With `en` = 0 and `req_valid` = 1, `req` = 0100 → `req_ready` = 0 and nothing is captured.
  - Drop `en` mid-drain of 1111 → all four indices are still emitted.
- **Reset mid-operation.** Accept 1110, complete one handshake (`y` = 1), then pulse `rst_n` low asynchronously between edges. All outputs go to their reset values immediately and the remaining bits 2 and 3 are never emitted.
- **Back-to-back vectors.** Accept 1000 and, as soon as `req_ready` = 1, accept 0011:
  - Expect `y` = 3, then one bubble cycle, then `y` = 0, 1.
  - `multi` shows 0 during the first vector and 1 during the second.
